// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide beside the ALU: shift-add / restoring shift-subtract, BITS_PER_CYCLE bits per CALC cycle.
// Latency XLEN/BITS_PER_CYCLE+3 from accept to out_valid (2 on early-out cases when MULDIV_EARLY_OUT_EN is defined).
// No output backpressure: out_valid is a one-cycle strobe; out_stall holds decode while an operation is in flight.
module ex_muldiv_unit #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [2:0]      in_func3,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [4:0]      in_rd,
   input  logic            in_flush,
   output logic            out_valid,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_busy,
   output logic            out_stall
);

   localparam int STEPS = XLEN / BITS_PER_CYCLE;
   localparam int CW    = $clog2(STEPS + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [2:0]        func3_q;
   logic [XLEN-1:0]   rs1_q, rs2_q, opb_q;
   logic [4:0]        rd_q;
   logic [2*XLEN-1:0] acc_q, acc_step;
   logic [CW-1:0]     cnt_q;

   logic            is_div, signed1, signed2, neg1, neg2, neg_res;
   logic            div0, ovf;
   logic [XLEN-1:0] abs1, abs2, spec_res, fix_res;

   // Operand decode works off the latched copies, which stay stable for the whole operation.
   always_comb begin
      is_div   = func3_q[2];
      signed1  = (func3_q == F_MULH) || (func3_q == F_MULHSU) ||
                 (func3_q == F_DIV)  || (func3_q == F_REM);
      signed2  = (func3_q == F_MULH) || (func3_q == F_DIV) || (func3_q == F_REM);
      neg1     = signed1 & rs1_q[XLEN-1];
      neg2     = signed2 & rs2_q[XLEN-1];
      abs1     = neg1 ? -rs1_q : rs1_q;
      abs2     = neg2 ? -rs2_q : rs2_q;
      // Remainder sign follows the dividend; every other result takes the product/quotient sign.
      neg_res  = (func3_q[2] & func3_q[1]) ? neg1 : (neg1 ^ neg2);
      div0     = (rs2_q == '0);
      ovf      = ((func3_q == F_DIV) || (func3_q == F_REM)) &&
                 (rs1_q == MIN_NEG) && (rs2_q == '1);
      spec_res = func3_q[1] ? (div0 ? rs1_q : '0) : (div0 ? '1 : MIN_NEG);
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            early_hit;
   logic [XLEN-1:0] early_res;

   always_comb begin
      early_hit = is_div ? (div0 | ovf) : ((rs1_q == '0) || (rs2_q == '0));
      early_res = is_div ? spec_res : '0;
   end
`endif

   // One CALC cycle: BITS_PER_CYCLE iterations over the {high, low} accumulator.
   // Multiply: multiplier shifts out of the low half, partial sums enter the high half.
   // Divide: {remainder, dividend} shifts left, quotient bits enter at the bottom.
   always_comb begin
      logic [2*XLEN-1:0] step;
      logic [XLEN:0]     upper;
      logic [XLEN:0]     trial;
      step  = acc_q;
      upper = '0;
      trial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (is_div) begin
            trial = step[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
            if (!trial[XLEN])
               step = {trial[XLEN-1:0], step[XLEN-2:0], 1'b1};
            else
               step = {step[2*XLEN-2:0], 1'b0};
         end else begin
            upper = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opb_q} : '0);
            step  = {upper, step[XLEN-1:1]};
         end
      end
      acc_step = step;
   end

   always_comb begin
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   sel;
      prod    = neg_res ? -acc_q : acc_q;
      sel     = func3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      fix_res = '0;
      if (!is_div)
         fix_res = (func3_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (div0 || ovf)
         fix_res = spec_res;
      else
         fix_res = neg_res ? -sel : sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid && !in_flush) state_d = S_PREP;
         S_PREP: begin
            if (in_flush)
               state_d = S_IDLE;
`ifdef MULDIV_EARLY_OUT_EN
            else if (early_hit)
               state_d = S_DONE;
`endif
            else
               state_d = S_CALC;
         end
         S_CALC: begin
            if (in_flush)               state_d = S_IDLE;
            else if (cnt_q == CW'(1))   state_d = S_FIX;
         end
         S_FIX:  state_d = in_flush ? S_IDLE : S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         func3_q    <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         opb_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_result <= '0;
         out_rd     <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid && !in_flush) begin
                  func3_q <= in_func3;
                  rs1_q   <= in_rs1_data;
                  rs2_q   <= in_rs2_data;
                  rd_q    <= in_rd;
               end
            end
            S_PREP: begin
               opb_q <= abs2;
               acc_q <= {{XLEN{1'b0}}, abs1};
               cnt_q <= CW'(STEPS);
`ifdef MULDIV_EARLY_OUT_EN
               if (!in_flush && early_hit) begin
                  out_result <= early_res;
                  out_rd     <= rd_q;
               end
`endif
            end
            S_CALC: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q - CW'(1);
            end
            S_FIX: begin
               // A flushed operation leaves the previous result visible.
               if (!in_flush) begin
                  out_result <= fix_res;
                  out_rd     <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign out_busy  = (state_q != S_IDLE);
   assign out_stall = ((state_q == S_IDLE) & in_valid & ~in_flush) |
                      (out_busy & (state_q != S_DONE));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (default parameters) against an arithmetic reference model.
module tb_ex_muldiv_unit;

   localparam int XLEN = 32;
   localparam int BPC  = 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic [2:0]      in_func3;
   logic [XLEN-1:0] in_rs1_data, in_rs2_data;
   logic [4:0]      in_rd;
   logic            in_flush;
   logic            out_valid;
   logic [XLEN-1:0] out_result;
   logic [4:0]      out_rd;
   logic            out_busy;
   logic            out_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_func3(in_func3),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd(in_rd),
      .in_flush(in_flush), .out_valid(out_valid), .out_result(out_result),
      .out_rd(out_rd), .out_busy(out_busy), .out_stall(out_stall)
   );

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb, q;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = '0;
      q  = 0;
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            q = sa / sb; return q[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            q = sa % sb; return q[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (f[2] && (b == 0)) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
      if (!f[2] && (a == 0 || b == 0)) return 2;
`endif
      return XLEN / BPC + 3;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge: presents one op, waits (bounded) for out_valid, reports what was seen.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] ord, output int lat, output bit stall_ok);
      in_valid = 1'b1; in_func3 = f; in_rs1_data = a; in_rs2_data = b; in_rd = rd;
      stall_ok = 1'b1; lat = -1; res = 'x; ord = 'x;
      #1;
      if (out_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            lat = c; res = out_result; ord = out_rd;
            if (out_stall !== 1'b0) stall_ok = 1'b0;
            break;
         end
         if (out_stall !== 1'b1) stall_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_func3 = '0; in_rs1_data = '0; in_rs2_data = '0;
      in_rd = '0; in_flush = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", out_busy); end
      checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", out_result); end
      checks++; if (out_rd !== 5'h0) begin errors++; $display("FAIL reset_rd got %h want 0", out_rd); end
      checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", out_stall); end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [2:0]  df[10] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] da[10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                              32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
      logic [31:0] db[10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd2, 32'd2, 32'd0, 32'd0};
      logic [31:0] dx[10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h80000000,
                              32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100};
      logic [31:0] res;
      logic [4:0]  ord;
      int          lat;
      bit          sok;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         do_op(df[i], da[i], db[i], 5'(5 + i), res, ord, lat, sok);
         checks++; if (res !== dx[i]) begin errors++; $display("FAIL dir_result[%0d] got %h want %h", i, res, dx[i]); end
         checks++; if (ord !== 5'(5 + i)) begin errors++; $display("FAIL dir_rd[%0d] got %0d want %0d", i, ord, 5 + i); end
         checks++; if (lat != exp_lat(df[i], da[i], db[i])) begin errors++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, exp_lat(df[i], da[i], db[i])); end
         checks++; if (!sok) begin errors++; $display("FAIL dir_stall[%0d] got bad stall profile want high until DONE", i); end
      end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, res;
      logic [4:0]  rd, ord;
      int          lat;
      bit          sok;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7)); a = rnd_opnd(); b = rnd_opnd(); rd = 5'($urandom);
         @(negedge clk);
         do_op(f, a, b, rd, res, ord, lat, sok);
         checks++; if (res !== ref_res(f, a, b)) begin errors++; $display("FAIL rnd_result[%0d] f=%0d a=%h b=%h got %h want %h", i, f, a, b, res, ref_res(f, a, b)); end
         checks++; if (ord !== rd || lat != exp_lat(f, a, b)) begin errors++; $display("FAIL rnd_rd_lat[%0d] got rd=%0d lat=%0d want rd=%0d lat=%0d", i, ord, lat, rd, exp_lat(f, a, b)); end
      end
   endtask

   task automatic test_flush();
      logic [31:0] held, res;
      logic [4:0]  held_rd, ord;
      int          lat;
      bit          sok, saw_valid;
      // Flush alongside in_valid in IDLE blocks the accept.
      @(negedge clk);
      held = out_result; held_rd = out_rd;
      in_valid = 1'b1; in_flush = 1'b1; in_func3 = 3'd0; in_rs1_data = 32'd3; in_rs2_data = 32'd3;
      #1;
      checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b want 0", out_stall); end
      @(negedge clk);
      checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", out_busy); end
      in_flush = 1'b0;
      // Abort a DIVU mid-CALC.
      in_func3 = 3'd5; in_rs1_data = 32'd1000; in_rs2_data = 32'd7; in_rd = 5'd9;
      @(posedge clk);
      #1 in_valid = 1'b0;
      saw_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) saw_valid = 1'b1;
      end
      in_flush = 1'b1;
      @(posedge clk);
      #1 in_flush = 1'b0;
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1'b1;
      checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", out_busy); end
      checks++; if (saw_valid) begin errors++; $display("FAIL flush_no_valid got valid=1 want 0"); end
      checks++; if (out_result !== held || out_rd !== held_rd) begin errors++; $display("FAIL flush_held got %h/%0d want %h/%0d", out_result, out_rd, held, held_rd); end
      do_op(3'd0, 32'd12345, 32'd678, 5'd17, res, ord, lat, sok);
      checks++; if (res !== 32'd8369910 || ord !== 5'd17) begin errors++; $display("FAIL flush_next_mul got %h/%0d want %h/17", res, ord, 32'd8369910); end
      checks++; if (lat != exp_lat(3'd0, 32'd12345, 32'd678)) begin errors++; $display("FAIL flush_next_lat got %0d want %0d", lat, exp_lat(3'd0, 32'd12345, 32'd678)); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      logic [4:0]  ord;
      int          lat;
      bit          sok;
      @(negedge clk);
      in_valid = 1'b1; in_func3 = 3'd4; in_rs1_data = 32'hFFFF0000; in_rs2_data = 32'd3; in_rd = 5'd30;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 20; c++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_busy !== 1'b0 || out_stall !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got v=%b b=%b s=%b want 0", out_valid, out_busy, out_stall); end
      checks++; if (out_result !== 32'h0 || out_rd !== 5'h0) begin errors++; $display("FAIL rstmid_data got %h/%0d want 0/0", out_result, out_rd); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(3'd6, 32'hFFFFFF9C, 32'd7, 5'd3, res, ord, lat, sok);
      checks++; if (res !== 32'hFFFFFFFE || ord !== 5'd3) begin errors++; $display("FAIL rstmid_after got %h/%0d want fffffffe/3", res, ord); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res, prev;
      logic [4:0]  ord;
      int          lat;
      bit          sok;
      @(negedge clk);
      do_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd1, res, ord, lat, sok);
      prev = res;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || out_result !== prev) begin errors++; $display("FAIL b2b_strobe got v=%b r=%h want v=0 r=%h", out_valid, out_result, prev); end
      do_op(3'd7, 32'hDEADBEEF, 32'h1234, 5'd2, res, ord, lat, sok);
      checks++; if (res !== ref_res(3'd7, 32'hDEADBEEF, 32'h1234) || lat != exp_lat(3'd7, 32'hDEADBEEF, 32'h1234)) begin errors++; $display("FAIL b2b_second got %h lat %0d want %h lat %0d", res, lat, ref_res(3'd7, 32'hDEADBEEF, 32'h1234), exp_lat(3'd7, 32'hDEADBEEF, 32'h1234)); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle RV32M multiply/divide unit for the execute stage; sits beside the single-cycle ALU.
- Accepts forwarded operands plus func3 when decode marks the instruction as M-extension (funct7=0000001).
- Iterates shift-add/shift-subtract, then returns the result with its rd to the EX/MEM register.
- Drives a stall to the decode hazard unit while busy.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, quotient/product bits retired per CALC cycle; must be 1, 2 or 4 and divide XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  M-instruction present in EX
- in_func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_rs1_data  in  XLEN  forwarded rs1 value
- in_rs2_data  in  XLEN  forwarded rs2 value
- in_rd  in  5  destination register
- in_flush  in  1  branch/jump flush from execute; aborts the operation
- out_valid  out  1  one-cycle result strobe
- out_result  out  XLEN  result, held until the next accept
- out_rd  out  5  rd of the result, held with out_result
- out_busy  out  1  operation in flight
- out_stall  out  1  combinational; freeze PC, IF/ID and ID/EX

Behaviour:
- Reset: state IDLE; out_valid, out_busy, out_result and out_rd are 0. Reset mid-operation discards the operation with no out_valid.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- Accept: in IDLE with in_valid=1 and in_flush=0, latch func3, operands and rd; go to PREP. Inputs are ignored in any other state.
- PREP: take absolute values for signed operands:
  - MULH: both operands.
  - MULHSU: rs1 only.
  - DIV/REM: both operands.
  - Record the result sign. Load counter = XLEN/BITS_PER_CYCLE.
- CALC: each cycle retire BITS_PER_CYCLE bits.
  - Multiply: 2*XLEN-bit accumulator.
  - Divide: restoring, XLEN-bit remainder.
  - Decrement the counter; go to FIX when it reaches 1.
- FIX: negate if the sign requires it, then select the result:
  - low half for MUL.
  - high half for MULH/MULHSU/MULHU.
  - quotient for DIV/DIVU.
  - remainder for REM/REMU.
- DONE: out_valid=1 for exactly one cycle, result registered; then IDLE.
- Latency: accept at cycle 0 gives out_valid at cycle XLEN/BITS_PER_CYCLE+3 (35 for defaults).
- Divide special cases, decided in PREP; CALC still runs unless the optional feature is enabled:
  - Divide by zero: quotient all ones; remainder = rs1.
  - Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- out_busy: 1 from the cycle after accept through DONE inclusive.
- out_stall = (IDLE & in_valid & ~in_flush) | (out_busy & ~DONE).
  - Stall drops in the DONE cycle, so EX/MEM captures the result on that edge.
- Flush: in_flush=1 in PREP, CALC or FIX moves to IDLE on the next edge. out_valid is never raised, and out_result/out_rd keep their old values. Flush in DONE does not suppress out_valid; EX/MEM flush logic discards the result.
- Back-to-back: a new accept is possible the cycle after DONE.
- Width: all arithmetic unsigned internally; MULHSU treats rs2 as unsigned.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: PREP detects these cases and goes directly to DONE, giving out_valid at cycle 2:
  - divide by zero.
  - signed overflow.
  - either multiply operand zero (result 0).
  - Other operations keep full latency.
- Undefined: every operation takes full latency; results are identical.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> out_valid at cycle 35; out_result=0xFFFFFFEB, out_rd=5; out_stall high in cycles 0..34.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 100. With MULDIV_EARLY_OUT_EN, both give out_valid at cycle 2.
- Accept DIVU, assert in_flush at cycle 10 -> out_busy=0 at cycle 11, no out_valid; a new MUL accepted at cycle 11 completes normally.
- rst_n low at cycle 20 of a DIV -> all outputs 0 immediately; after release, an in_valid op is accepted and gives correct results. Parameter sweep BITS_PER_CYCLE=2,4 gives latency 19 and 11 with identical results.
